seven_segment_scan_decoder: RTL and testbench

Receive-side counterpart of the stopwatch's multiplexed 4-digit display driver: samples the active-low anode and segment buses and filters out scan transitions. Decodes each digit slot back to BCD and publishes a complete minutes/seconds frame once all four slots have been seen. Sits on the bench/monitor side of the display interface, for self-checking of the display path and for board loopback capture.

---
 rtl/seven_segment_scan_decoder_pkg.sv | 42 ++++
 rtl/seven_segment_pattern_decoder.sv | 32 +++
 rtl/seven_segment_scan_decoder.sv | 197 +++++++++++++++++++
 tb/tb_seven_segment_scan_decoder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_scan_decoder_pkg.sv
// Shared constants for the multiplexed 7-segment display path: segment codes,
// anode slot patterns, and anode classification used by the scan decoder.
package seven_seg_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] AN_MIN1 = 4'b0111;
  localparam logic [3:0] AN_MIN0 = 4'b1011;
  localparam logic [3:0] AN_SEC1 = 4'b1101;
  localparam logic [3:0] AN_SEC0 = 4'b1110;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  typedef enum logic [1:0] {
    AN_IDLE,
    AN_SINGLE,
    AN_MULTI
  } an_class_e;

  // Anodes are active-low, so the number of zero bits is the number of lit slots.
  function automatic an_class_e classify_anode(input logic [3:0] an);
    logic [2:0] lows;
    lows = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!an[i]) lows = lows + 3'd1;
    end
    if (lows == 3'd0) return AN_IDLE;
    if (lows == 3'd1) return AN_SINGLE;
    return AN_MULTI;
  endfunction

endpackage

// File: rtl/seven_segment_pattern_decoder.sv
// Combinational inverse of the display encoder: seg[6:0] (active-low, dp
// position treated as unlit) back to a BCD digit plus blank/invalid flags.
module seven_segment_pattern_decoder
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       blank,
  output logic       invalid
);

  always_comb begin
    digit   = DIGIT_BLANK;
    blank   = 1'b0;
    invalid = 1'b0;
    case ({1'b1, seg})
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: blank = 1'b1;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Display-bus monitor: filters scan transitions on the active-low anode/segment
// bus and rebuilds mm:ss frames. Define SEVEN_SEG_DECODER_DP_EN to add out_dp.
module seven_segment_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic [3:0] in_an,
  input  logic [7:0] in_seg,
  output logic [3:0] out_minute1,
  output logic [3:0] out_minute0,
  output logic [3:0] out_second1,
  output logic [3:0] out_second0,
  output logic [3:0] out_blank,
`ifdef SEVEN_SEG_DECODER_DP_EN
  output logic [3:0] out_dp,
`endif
  output logic       out_frame_valid,
  output logic       out_error,
  output logic       out_stale
);

  localparam logic [7:0]  STABLE_W  = 8'(STABLE_CYCLES);
  localparam logic [23:0] TIMEOUT_W = 24'(TIMEOUT_CYCLES);

  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic [11:0]      prev_q, prev_d;
  logic [7:0]       stab_cnt_q, stab_cnt_d;
  logic             committed_q, committed_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0][3:0]  shadow_digit_q, shadow_digit_d;
  logic [3:0]       shadow_blank_q, shadow_blank_d;
  logic [3:0][3:0]  digit_q, digit_d;
  logic [3:0]       blank_q, blank_d;
  logic             frame_valid_q, frame_valid_d;
  logic             error_q, error_d;
  logic             stale_q, stale_d;
  logic [23:0]      to_cnt_q, to_cnt_d;
`ifdef SEVEN_SEG_DECODER_DP_EN
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [3:0]       dp_q, dp_d;
`endif

  logic [3:0]  dec_digit;
  logic        dec_blank;
  logic        dec_invalid;
  logic        qualify;
  logic        slot_commit;
  logic        publish;
  logic        code_bad;
  logic [3:0]  commit_digit;
  logic        commit_blank;
  an_class_e   an_class;

  seven_segment_pattern_decoder u_decoder (
    .seg     (seg_q[6:0]),
    .digit   (dec_digit),
    .blank   (dec_blank),
    .invalid (dec_invalid)
  );

  always_comb begin
    an_d           = in_an;
    seg_d          = in_seg;
    prev_d         = {an_q, seg_q};
    stab_cnt_d     = stab_cnt_q;
    committed_d    = committed_q;
    mask_d         = mask_q;
    shadow_digit_d = shadow_digit_q;
    shadow_blank_d = shadow_blank_q;
    digit_d        = digit_q;
    blank_d        = blank_q;
    error_d        = error_q;
    to_cnt_d       = to_cnt_q;
`ifdef SEVEN_SEG_DECODER_DP_EN
    shadow_dp_d    = shadow_dp_q;
    dp_d           = dp_q;
`endif

    // A change restarts the dwell; a steady bus counts up and commits once per dwell.
    if ({an_q, seg_q} != prev_q) begin
      stab_cnt_d  = 8'd1;
      committed_d = 1'b0;
    end else if (stab_cnt_q != 8'hFF) begin
      stab_cnt_d = stab_cnt_q + 8'd1;
    end
    qualify = !committed_d && (stab_cnt_d == STABLE_W);
    if (qualify) committed_d = 1'b1;

    an_class    = classify_anode(an_q);
    slot_commit = qualify && (an_class == AN_SINGLE);

`ifdef SEVEN_SEG_DECODER_DP_EN
    code_bad = dec_invalid;
`else
    code_bad = dec_invalid || !seg_q[7];
`endif
    commit_digit = code_bad ? DIGIT_BLANK : dec_digit;
    commit_blank = dec_blank && !code_bad;

    if (qualify && ((an_class == AN_MULTI) || ((an_class == AN_SINGLE) && code_bad)))
      error_d = 1'b1;

    // Publishing clears the mask first so a commit in the same cycle starts the next frame.
    publish       = (mask_q == 4'hF);
    frame_valid_d = publish;
    if (publish) begin
      digit_d = shadow_digit_q;
      blank_d = shadow_blank_q;
      mask_d  = 4'h0;
`ifdef SEVEN_SEG_DECODER_DP_EN
      dp_d    = shadow_dp_q;
`endif
    end

    if (slot_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (!an_q[i]) begin
          shadow_digit_d[i] = commit_digit;
          shadow_blank_d[i] = commit_blank;
`ifdef SEVEN_SEG_DECODER_DP_EN
          shadow_dp_d[i]    = !seg_q[7];
`endif
        end
      end
      mask_d = mask_d | ~an_q;
    end

    if (slot_commit) begin
      to_cnt_d = 24'd0;
    end else if (to_cnt_q != TIMEOUT_W) begin
      to_cnt_d = to_cnt_q + 24'd1;
    end
    // A stalled scan drops the partial frame; published outputs are left alone.
    stale_d = (to_cnt_d == TIMEOUT_W);
    if (stale_d) mask_d = 4'h0;
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      an_q           <= 4'hF;
      seg_q          <= 8'hFF;
      prev_q         <= {4'hF, 8'hFF};
      stab_cnt_q     <= 8'd0;
      committed_q    <= 1'b0;
      mask_q         <= 4'h0;
      shadow_digit_q <= {4{DIGIT_BLANK}};
      shadow_blank_q <= 4'h0;
      digit_q        <= {4{DIGIT_BLANK}};
      blank_q        <= 4'h0;
      frame_valid_q  <= 1'b0;
      error_q        <= 1'b0;
      stale_q        <= 1'b0;
      to_cnt_q       <= 24'd0;
`ifdef SEVEN_SEG_DECODER_DP_EN
      shadow_dp_q    <= 4'h0;
      dp_q           <= 4'h0;
`endif
    end else begin
      an_q           <= an_d;
      seg_q          <= seg_d;
      prev_q         <= prev_d;
      stab_cnt_q     <= stab_cnt_d;
      committed_q    <= committed_d;
      mask_q         <= mask_d;
      shadow_digit_q <= shadow_digit_d;
      shadow_blank_q <= shadow_blank_d;
      digit_q        <= digit_d;
      blank_q        <= blank_d;
      frame_valid_q  <= frame_valid_d;
      error_q        <= error_d;
      stale_q        <= stale_d;
      to_cnt_q       <= to_cnt_d;
`ifdef SEVEN_SEG_DECODER_DP_EN
      shadow_dp_q    <= shadow_dp_d;
      dp_q           <= dp_d;
`endif
    end
  end

  assign out_minute1     = digit_q[3];
  assign out_minute0     = digit_q[2];
  assign out_second1     = digit_q[1];
  assign out_second0     = digit_q[0];
  assign out_blank       = blank_q;
  assign out_frame_valid = frame_valid_q;
  assign out_error       = error_q;
  assign out_stale       = stale_q;
`ifdef SEVEN_SEG_DECODER_DP_EN
  assign out_dp          = dp_q;
`endif

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Bench for seven_segment_scan_decoder: directed scans plus random dwell
// sequences checked against a dwell-level reference model of the display bus.
module tb_seven_segment_scan_decoder;
  import seven_seg_pkg::*;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 300;

  logic       in_clock = 1'b0;
  logic       in_reset = 1'b1;
  logic [3:0] in_an    = 4'hF;
  logic [7:0] in_seg   = 8'hFF;
  logic [3:0] out_minute1, out_minute0, out_second1, out_second0, out_blank;
  logic       out_frame_valid, out_error, out_stale;
`ifdef SEVEN_SEG_DECODER_DP_EN
  logic [3:0] out_dp;
`endif

  int errors = 0;
  int checks = 0;

  logic [19:0] obs_q[$];
  logic [19:0] exp_q[$];
  logic [7:0]  code_table [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                   8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [3:0]  an_table [4];
  logic [3:0]  m_digit [4];
  logic [3:0]  m_blank;
  logic [3:0]  m_seen;
  logic        m_error;
  logic [19:0] m_last;

  seven_segment_scan_decoder #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .in_clock        (in_clock),
    .in_reset        (in_reset),
    .in_an           (in_an),
    .in_seg          (in_seg),
    .out_minute1     (out_minute1),
    .out_minute0     (out_minute0),
    .out_second1     (out_second1),
    .out_second0     (out_second0),
    .out_blank       (out_blank),
`ifdef SEVEN_SEG_DECODER_DP_EN
    .out_dp          (out_dp),
`endif
    .out_frame_valid (out_frame_valid),
    .out_error       (out_error),
    .out_stale       (out_stale)
  );

  always #5 in_clock = ~in_clock;

  function automatic logic [19:0] cur_frame();
    return {out_minute1, out_minute0, out_second1, out_second0, out_blank};
  endfunction

  // Capture every published frame for later comparison with the model.
  always @(posedge in_clock) begin
    #1;
    if (out_frame_valid === 1'b1) obs_q.push_back(cur_frame());
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic model_decode(input logic [7:0] seg, output logic [3:0] d,
                              output logic b, output logic bad);
    logic [7:0] s;
`ifdef SEVEN_SEG_DECODER_DP_EN
    s = {1'b1, seg[6:0]};
`else
    s = seg;
`endif
    d = 4'hF;
    b = 1'b0;
    bad = 1'b1;
    if (s == 8'hFF) begin
      b = 1'b1;
      bad = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      if (s == code_table[i]) begin
        d = 4'(i);
        bad = 1'b0;
      end
    end
  endtask

  // A dwell of at least STABLE cycles lands on the slot its single lit anode names.
  task automatic model_dwell(input logic [3:0] an, input logic [7:0] seg, input int len);
    int z, k;
    logic [3:0] d;
    logic b, bad;
    logic [19:0] f;
    if (len < STABLE) return;
    z = 0;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (!an[i]) begin
        z++;
        k = i;
      end
    end
    if (z >= 2) m_error = 1'b1;
    if (z == 1) begin
      model_decode(seg, d, b, bad);
      if (bad) m_error = 1'b1;
      m_digit[k] = d;
      m_blank[k] = b;
      m_seen[k]  = 1'b1;
      if (m_seen == 4'hF) begin
        f = {m_digit[3], m_digit[2], m_digit[1], m_digit[0], m_blank};
        exp_q.push_back(f);
        m_last = f;
        m_seen = 4'h0;
      end
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] an, input logic [7:0] seg, input int len);
    in_an  = an;
    in_seg = seg;
    model_dwell(an, seg, len);
    repeat (len) @(negedge in_clock);
  endtask

  task automatic scan4(input logic [7:0] s_min1, input logic [7:0] s_min0,
                       input logic [7:0] s_sec1, input logic [7:0] s_sec0, input bit glitch);
    apply_stimulus(AN_MIN1, s_min1, 10);
    if (glitch) apply_stimulus(4'b0011, 8'h80, 2);
    apply_stimulus(AN_MIN0, s_min0, 10);
    if (glitch) apply_stimulus(4'b0011, 8'h80, 2);
    apply_stimulus(AN_SEC1, s_sec1, 10);
    if (glitch) apply_stimulus(4'b0011, 8'h80, 2);
    apply_stimulus(AN_SEC0, s_sec0, 10);
  endtask

  task automatic compare_frames(input string tag);
    int n;
    apply_stimulus(4'hF, 8'hFF, 12);
    check_output({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_output({tag, "_frame"}, 32'(obs_q[i]), 32'(exp_q[i]));
    check_output({tag, "_outputs"}, 32'(cur_frame()), 32'(m_last));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    in_an    = 4'hF;
    in_seg   = 8'hFF;
    in_reset = 1'b1;
    repeat (3) @(negedge in_clock);
    in_reset = 1'b0;
    for (int i = 0; i < 4; i++) m_digit[i] = 4'hF;
    m_blank = 4'h0;
    m_seen  = 4'h0;
    m_error = 1'b0;
    m_last  = {16'hFFFF, 4'h0};
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic latency_scan();
    int cycles;
    bit found;
    apply_stimulus(AN_MIN1, 8'hB0, 10);
    apply_stimulus(AN_MIN0, 8'h99, 10);
    apply_stimulus(AN_SEC1, 8'hF8, 10);
    in_an  = AN_SEC0;
    in_seg = 8'h82;
    model_dwell(AN_SEC0, 8'h82, 10);
    cycles = 0;
    found  = 0;
    while (!found && cycles < 20) begin
      @(posedge in_clock);
      #1;
      cycles++;
      if (out_frame_valid === 1'b1) found = 1;
    end
    check_output("frame_latency", found ? 32'(cycles) : 32'd0, 32'(STABLE + 2));
    @(negedge in_clock);
    repeat (4) @(negedge in_clock);
  endtask

  task automatic random_round(input int n_dwells);
    logic [3:0] pa, pa_prev;
    logic [7:0] ps, ps_prev;
    int r, q;
    pa_prev = in_an;
    ps_prev = in_seg;
    for (int n = 0; n < n_dwells; n++) begin
      do begin
        r = int'($urandom_range(0, 19));
        if (r < 15) pa = an_table[r % 4];
        else if (r < 17) pa = 4'hF;
        else pa = 4'($urandom_range(0, 15));
        q = int'($urandom_range(0, 19));
        if (q < 14) ps = code_table[q % 10];
        else if (q < 17) ps = 8'hFF;
        else ps = 8'($urandom_range(0, 255));
      end while ({pa, ps} == {pa_prev, ps_prev});
      apply_stimulus(pa, ps, int'($urandom_range(1, 9)));
      pa_prev = pa;
      ps_prev = ps;
    end
  endtask

  initial begin
    an_table[0] = AN_SEC0;
    an_table[1] = AN_SEC1;
    an_table[2] = AN_MIN0;
    an_table[3] = AN_MIN1;
    @(negedge in_clock);
    do_reset();
    check_output("reset_digits", 32'({out_minute1, out_minute0, out_second1, out_second0}), 32'hFFFF);
    check_output("reset_blank", 32'(out_blank), 32'h0);
    check_output("reset_valid", 32'(out_frame_valid), 32'h0);
    check_output("reset_error", 32'(out_error), 32'h0);
    check_output("reset_stale", 32'(out_stale), 32'h0);

    $display("[TB] basic scan");
    scan4(8'hC0, 8'hF9, 8'hA4, 8'hB0, 1'b0);
    compare_frames("basic");
    check_output("basic_digits", 32'({out_minute1, out_minute0, out_second1, out_second0}), 32'h0123);
    check_output("basic_error", 32'(out_error), 32'h0);

    latency_scan();
    compare_frames("latency");

    $display("[TB] glitch scan");
    scan4(8'hC0, 8'hF9, 8'hA4, 8'hB0, 1'b1);
    compare_frames("glitch");
    check_output("glitch_error", 32'(out_error), 32'h0);

    $display("[TB] blink scan");
    scan4(8'hFF, 8'hFF, 8'h92, 8'h90, 1'b0);
    compare_frames("blink");
    check_output("blink_digits", 32'({out_minute1, out_minute0, out_second1, out_second0}), 32'hFF59);
    check_output("blink_blank", 32'(out_blank), 32'hC);
    check_output("blink_error", 32'(out_error), 32'h0);

    $display("[TB] multi anode");
    apply_stimulus(4'b0101, 8'hC0, 10);
    apply_stimulus(4'hF, 8'hFF, 2);
    check_output("multi_error", 32'(out_error), 32'h1);
    scan4(8'h99, 8'h82, 8'hF8, 8'h80, 1'b0);
    compare_frames("multi_next");
    check_output("multi_sticky", 32'(out_error), 32'h1);

    $display("[TB] bad code");
    do_reset();
    scan4(8'hC0, 8'hF9, 8'hA4, 8'hAA, 1'b0);
    compare_frames("badcode");
    check_output("badcode_sec0", 32'(out_second0), 32'hF);
    check_output("badcode_blank0", 32'(out_blank[0]), 32'h0);
    check_output("badcode_error", 32'(out_error), 32'h1);

    $display("[TB] stale");
    do_reset();
    scan4(8'hF9, 8'hA4, 8'hB0, 8'h99, 1'b0);
    compare_frames("stale_pre");
    apply_stimulus(AN_MIN1, 8'h82, 10);
    apply_stimulus(AN_MIN0, 8'hF8, 10);
    apply_stimulus(4'hF, 8'hFF, TIMEOUT - 40);
    check_output("stale_early", 32'(out_stale), 32'h0);
    repeat (60) @(negedge in_clock);
    check_output("stale_set", 32'(out_stale), 32'h1);
    check_output("stale_hold", 32'(cur_frame()), 32'(m_last));
    m_seen = 4'h0;
    apply_stimulus(AN_SEC0, 8'h90, 10);
    check_output("stale_clear", 32'(out_stale), 32'h0);
    apply_stimulus(AN_SEC1, 8'h92, 10);
    compare_frames("stale_partial");
    apply_stimulus(AN_MIN0, 8'h80, 10);
    apply_stimulus(AN_MIN1, 8'hC0, 10);
    compare_frames("stale_resume");

    $display("[TB] random rounds");
    for (int rnd = 0; rnd < 3; rnd++) begin
      do_reset();
      random_round(40);
      compare_frames("random");
      check_output("random_error", 32'(out_error), 32'(m_error));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
